store_align: RTL and testbench
==============================

Name: store_align

Overview:
- Store-side counterpart of the load data extender.
- Accepts one store request per handshake: byte address, rs2 data and the store size select.
- Produces word-aligned write beats (word address, shifted write data, 4-bit byte mask) to a word-wide data memory, with a write/ack handshake.
- Sits between the execute stage's store path and data memory; stalls the core via o_st_ready while a store is in flight.

Parameters:
- ADDR_W, 32, byte-address width; word address = {addr[ADDR_W-1:2], 2'b00}.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_st_valid  in  1  store request valid.
- o_st_ready  out  1  block can accept a request this cycle.
- i_st_addr  in  ADDR_W  byte address.
- i_st_data  in  32  store data, LSB-justified.
- i_sl_sel  in  3  size select: 000 sb, 001 sh, 010 sw; all others invalid.
- o_mem_we  out  1  write beat valid.
- o_mem_addr  out  ADDR_W  word-aligned address of the beat.
- o_mem_wdata  out  32  write data positioned in byte lanes.
- o_mem_bmask  out  4  byte enables; bit k enables wdata[8k+7:8k].
- i_mem_ack  in  1  memory accepted the current beat.
- o_err  out  1  one-cycle pulse: request dropped (invalid select, or misaligned when splitting is disabled).

Behaviour:
- Reset: one clock i_clk; asynchronous active-high reset i_reset. On reset, FSM goes to IDLE; o_st_ready=1; o_mem_we=0; o_mem_addr=0; o_mem_wdata=0; o_mem_bmask=0; o_err=0. Any in-flight request is discarded; no further beats are issued.
- FSM states: IDLE, BEAT0, BEAT1.
- IDLE: o_st_ready=1. When i_st_valid=1, the request is captured into registers.
  - Valid select: go to BEAT0.
  - Invalid select: pulse o_err next cycle, stay IDLE, no write.
- BEAT0: o_st_ready=0, o_mem_we=1, first beat driven.
  - On i_mem_ack: go to BEAT1 if the second mask is nonzero, else IDLE.
- BEAT1: o_mem_we=1, second beat driven. On i_mem_ack: go to IDLE.
- Latency: request accepted at edge N; o_mem_we=1 from cycle N+1.
- Ack may arrive in the same cycle o_mem_we rises (zero-wait memory). Best-case single-beat throughput is one store per 2 cycles.
- While waiting for ack, o_mem_addr, o_mem_wdata and o_mem_bmask stay stable.
- While o_st_ready=0, i_st_valid is ignored and nothing is captured.
- i_mem_ack outside BEAT0/BEAT1 is ignored.
- Lane math, with off = addr[1:0]:
  - Size mask: sb 0001, sh 0011, sw 1111.
  - m8 = sizemask << off (8 bits); d64 = {32'b0, data} << (8*off).
  - Beat0: bmask=m8[3:0], wdata=d64[31:0], addr=word address.
  - Beat1: bmask=m8[7:4], wdata=d64[63:32], addr=word address + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
- Bytes outside the mask carry the shifted value (zeros allowed); memory must honour bmask only.
- o_mem_we and o_err never assert in the same cycle.

Optional Feature:
- Macro STORE_SPLIT_EN.
- Defined: word-crossing stores (sh at off=3; sw at off=1,2,3) are split into BEAT0+BEAT1 as above.
- Undefined: any crossing store (m8[7:4]≠0) is dropped at capture. o_err pulses one cycle, no beat is issued, FSM stays IDLE, and BEAT1 is unreachable.
- Aligned and non-crossing stores behave identically in both builds.

Test Plan:
- Reset asserted mid-BEAT0 (sw, addr 0x100, ack withheld) -> all outputs 0 and o_st_ready=1 within the reset cycle; no beat after release.
- sb addr 0x00000203 data 0xDEADBEEF sel 000, ack same cycle -> one beat: addr 0x200, bmask 1000, wdata[31:24]=0xEF; o_st_ready back to 1 the following cycle.
- sh addr 0x12 data 0x0000ABCD, ack delayed 3 cycles -> addr 0x10, bmask 1100, wdata 0xABCD0000, held stable 4 cycles; a second valid request during the wait is not captured.
- sw addr 0xFFFFFFFE data 0x11223344 (STORE_SPLIT_EN defined) -> beat0 addr 0xFFFFFFFC bmask 1100 wdata[31:16]=0x3344; beat1 addr 0x00000000 bmask 0011 wdata[15:0]=0x1122.
- Same sw without STORE_SPLIT_EN -> o_err pulses 1 cycle, o_mem_we stays 0, o_st_ready stays 1.
- sel 011 and sel 111 requests -> o_err pulse each, no write; a following sw addr 0x4 proceeds normally with bmask 1111.

Source files
------------

// File: rtl/store_align.sv
// Store aligner: turns sb/sh/sw requests into word-aligned masked write beats.
// Define STORE_SPLIT_EN to split word-crossing stores into two beats.
module store_align #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_data,
    input  logic [2:0]        i_sl_sel,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ack,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    state_t state, state_nx;

    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic              sel_ok;
    logic [7:0]        m8;
    logic [63:0]       d64;
    logic              drop;
    logic              take;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata0_q;
    logic [31:0]       wdata1_q;
    logic [3:0]        mask0_q;
    logic [3:0]        mask1_q;
    logic              err_q;

    assign off = i_st_addr[1:0];

    always_comb begin
        size_mask = 4'b0000;
        sel_ok    = 1'b1;
        case (i_sl_sel)
            3'b000:  size_mask = 4'b0001;
            3'b001:  size_mask = 4'b0011;
            3'b010:  size_mask = 4'b1111;
            default: sel_ok = 1'b0;
        endcase
    end

    assign m8  = {4'b0000, size_mask} << off;
    assign d64 = {32'b0, i_st_data} << {off, 3'b000};

    // Without splitting, any request touching the next word is rejected.
`ifdef STORE_SPLIT_EN
    assign drop = !sel_ok;
`else
    assign drop = !sel_ok || (m8[7:4] != 4'b0000);
`endif

    assign take = (state == IDLE) && i_st_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        o_st_ready  = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0;
        o_mem_bmask = 4'b0000;
        unique case (state)
            IDLE: begin
                o_st_ready = 1'b1;
                if (i_st_valid && !drop) begin
                    state_nx = BEAT0;
                end
            end
            BEAT0: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = addr_q;
                o_mem_wdata = wdata0_q;
                o_mem_bmask = mask0_q;
                if (i_mem_ack) begin
`ifdef STORE_SPLIT_EN
                    state_nx = (mask1_q != 4'b0000) ? BEAT1 : IDLE;
`else
                    state_nx = IDLE;
`endif
                end
            end
            BEAT1: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = addr_q + ADDR_W'(4);
                o_mem_wdata = wdata1_q;
                o_mem_bmask = mask1_q;
                if (i_mem_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_q   <= '0;
            wdata0_q <= 32'h0;
            wdata1_q <= 32'h0;
            mask0_q  <= 4'b0000;
            mask1_q  <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            err_q <= take && drop;
            if (take && !drop) begin
                addr_q   <= {i_st_addr[ADDR_W-1:2], 2'b00};
                wdata0_q <= d64[31:0];
                wdata1_q <= d64[63:32];
                mask0_q  <= m8[3:0];
                mask1_q  <= m8[7:4];
            end
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_store_align.sv
// Scoreboard bench for store_align: directed stores, expected beats queued,
// monitor checks every presented beat and error pulse.
module tb_store_align;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  sl_sel;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ack;
    logic        err;

    typedef struct {
        bit          is_err;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  m;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   misses;
    int   ack_delay;
    int   wcnt;

    store_align #(.ADDR_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_st_valid  (st_valid),
        .o_st_ready  (st_ready),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .i_sl_sel    (sl_sel),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .i_mem_ack   (mem_ack),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: ack after ack_delay waiting cycles per beat.
    initial begin
        mem_ack = 1'b0;
        wcnt    = 0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt    = wcnt + 1;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Monitor: compare presented beats and error pulses with queue front.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mem_we && err) begin
                vectors++;
                misses++;
                $display("FAIL we_err_overlap: got we=1 err=1, want not both");
            end
            if (mem_we) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    misses++;
                    $display("FAIL beat_unexpected: got addr=%h wdata=%h bmask=%b, want no beat",
                             mem_addr, mem_wdata, mem_bmask);
                end else if (exp_q[0].is_err) begin
                    misses++;
                    $display("FAIL beat_vs_err: got beat addr=%h, want err pulse", mem_addr);
                    void'(exp_q.pop_front());
                end else begin
                    if (mem_addr !== exp_q[0].a || mem_wdata !== exp_q[0].w ||
                        mem_bmask !== exp_q[0].m) begin
                        misses++;
                        $display("FAIL beat: got addr=%h wdata=%h bmask=%b, want addr=%h wdata=%h bmask=%b",
                                 mem_addr, mem_wdata, mem_bmask,
                                 exp_q[0].a, exp_q[0].w, exp_q[0].m);
                    end
                    if (mem_ack) void'(exp_q.pop_front());
                end
            end
            if (err) begin
                vectors++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    misses++;
                    $display("FAIL err_unexpected: got err=1, want no err");
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
        exp_t e;
        e.is_err = 1'b0;
        e.a = a;
        e.w = w;
        e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.a = 32'h0;
        e.w = 32'h0;
        e.m = 4'b0;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Issue one request for a single cycle once the block is ready.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (!st_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!st_ready) begin
            vectors++;
            misses++;
            $display("FAIL ready_timeout: got ready=0, want 1");
        end
        st_addr  = a;
        st_data  = d;
        sl_sel   = s;
        st_valid = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            misses++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vectors   = 0;
        misses    = 0;
        ack_delay = 0;
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        sl_sel    = 3'b000;
        #1;
        check("rst_ready", 32'(st_ready), 32'h1);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a stalled beat.
        ack_delay = 1000;
        push_beat(32'h100, 32'h01020304, 4'b1111);
        send(32'h100, 32'h01020304, 3'b010);
        @(negedge clk);
        check("beat0_ready_low", 32'(st_ready), 32'h0);
        #5;
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(mem_we), 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_wdata", mem_wdata, 32'h0);
        check("midrst_bmask", 32'(mem_bmask), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_ready", 32'(st_ready), 32'h1);
        exp_q.delete();
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // sb at offset 3, zero-wait ack.
        push_beat(32'h200, 32'hEF000000, 4'b1000);
        send(32'h203, 32'hDEADBEEF, 3'b000);
        @(negedge clk);
        #1;
        check("sb_ready_back", 32'(st_ready), 32'h1);
        drain();

        // sh with three wait cycles; a request during the stall is ignored.
        ack_delay = 3;
        push_beat(32'h10, 32'hABCD0000, 4'b1100);
        send(32'h12, 32'h0000ABCD, 3'b001);
        #1;
        check("stall_ready_low", 32'(st_ready), 32'h0);
        st_addr  = 32'h40;
        st_data  = 32'h77;
        sl_sel   = 3'b000;
        st_valid = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
        drain();
        ack_delay = 0;

        // sb at offset 1, non-crossing.
        push_beat(32'h0, 32'h00005500, 4'b0010);
        send(32'h1, 32'h00000055, 3'b000);
        drain();

        // Crossing stores: split into two beats or dropped with err.
`ifdef STORE_SPLIT_EN
        push_beat(32'hFFFFFFFC, 32'h33440000, 4'b1100);
        push_beat(32'h00000000, 32'h00001122, 4'b0011);
        send(32'hFFFFFFFE, 32'h11223344, 3'b010);
        drain();
        push_beat(32'h0, 32'h34000000, 4'b1000);
        push_beat(32'h4, 32'h00000012, 4'b0001);
        send(32'h3, 32'h00001234, 3'b001);
        drain();
        ack_delay = 1;
        push_beat(32'h20, 32'hB2C3D400, 4'b1110);
        push_beat(32'h24, 32'h000000A1, 4'b0001);
        send(32'h21, 32'hA1B2C3D4, 3'b010);
        drain();
        ack_delay = 0;
`else
        push_err();
        send(32'hFFFFFFFE, 32'h11223344, 3'b010);
        #1;
        check("xerr_ready", 32'(st_ready), 32'h1);
        check("xerr_pulse", 32'(err), 32'h1);
        drain();
        push_err();
        send(32'h3, 32'h00001234, 3'b001);
        drain();
        push_err();
        send(32'h21, 32'hA1B2C3D4, 3'b010);
        drain();
`endif

        // Invalid selects, then a normal aligned word store.
        push_err();
        send(32'h8, 32'h12345678, 3'b011);
        push_err();
        send(32'h8, 32'h12345678, 3'b111);
        push_beat(32'h4, 32'hCAFEF00D, 4'b1111);
        send(32'h4, 32'hCAFEF00D, 3'b010);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
